cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Single-result common data bus (CDB) scheduler. ALU and load buffer each push completed results
//  (ROB tag + value) into a private queue; the arbiter broadcasts one result per cycle to RS, ROB and
//  load buffer. Round-robin between sources when both queues are non-empty. Flushed by ROB misprediction reset.
// PARAMETERS
//  DEPTH      2   entries per source queue (power of two, >=2)
//  PTR_W      1   log2(DEPTH); queue pointer width; count width is PTR_W+1
// PORTS
//  clk_in                 in   1            clock, all state on posedge
//  rst_n_in               in   1            asynchronous, active-low reset
//  rdy_in                 in   1            global ready; low = freeze all state
//  rob_cdb_rst_in         in   1            synchronous flush (misprediction)
//  alu_cdb_b_in           in   `ROBWidth    ALU result tag; 0 = no result this cycle
//  alu_cdb_result_in      in   `IDWidth     ALU result value
//  cdb_alu_rdy_out        out  1            ALU queue can accept (count != DEPTH)
//  lbuffer_cdb_b_in       in   `ROBWidth    load result tag; 0 = none
//  lbuffer_cdb_result_in  in   `IDWidth     load result value
//  cdb_lbuffer_rdy_out    out  1            load queue can accept
//  cdb_b_out              out  `ROBWidth    broadcast tag, registered; 0 = idle
//  cdb_result_out         out  `IDWidth     broadcast value, registered
//  cdb_src_out            out  1            0 = ALU, 1 = load buffer (debug/ROB)
// BEHAVIOUR
//  - Reset (rst_n_in low, async): queues empty, pointers 0, cdb_b_out=0, cdb_result_out=0, cdb_src_out=0,
//    last_grant=1 (ALU wins first contention). rdy_out reflects empty queues (1).
//  - rdy_in low: no push, no pop, outputs hold value; rdy_in outranks nothing above reset.
//  - rob_cdb_rst_in high (rdy_in high): queues emptied, cdb_b_out<=0; inputs that cycle discarded.
//  - Push: tag != 0 writes {tag,value} at tail. Push while rdy_out low is illegal (assert); rdy_out is
//    computed from count before this cycle's pop, so full+pop does not admit a same-cycle push.
//  - Grant (each cycle): only ALU queue non-empty -> ALU; only load -> load; both -> source != last_grant;
//    none -> cdb_b_out<=0. Winner head popped, driven to outputs at the edge, last_grant<=winner.
//  - Latency (macro off): input at edge N in queue, broadcast visible after edge N+1; 2 cycles.
//  - Same-cycle push+pop on one queue: count unchanged, tail and head both advance; wrap at DEPTH.
//  - Tag 0 is never broadcast; a flush mid-queue drops all queued entries with no partial broadcast.
//  - Sustained throughput 1 result/cycle; under dual saturation each source gets exactly 1/2.
// CONFIGURATION
//  CDB_ARB_BYPASS_EN defined: an arriving result whose queue is empty and which would win grant
//   (other queue empty, or contention and its source != last_grant) goes straight to outputs at the
//   same edge (1-cycle latency), not enqueued. Bypass counts as grant (last_grant updated).
//  Undefined: every result passes through its queue; fixed 2-cycle latency.
// STRUCTURE
//  constant.vh: `CDBDepth, `CDBPtrWidth, `CDBSrcALU (1'b0), `CDBSrcLBuffer (1'b1);
//   reuses `ROBWidth, `IDWidth.
//  One sub-module cdb_fifo (DEPTH-entry tag/value queue: push, pop, flush, empty, full, head data),
//   instantiated twice; arbitration, bypass and output registers live in cdb_arbiter.
// TESTING
//  1 ALU tag 3 val 0x11 alone -> cdb_b_out=3, result=0x11, src=0 two edges later (one with bypass).
//  2 ALU tag 4 and load tag 5 same cycle from reset -> tag 4 broadcast, tag 5 next cycle.
//  3 Both sources push every cycle while rdy_out high -> grants alternate 0,1,0,1; no loss, order
//    within each source preserved; rdy_out drops once queue reaches DEPTH.
//  4 Queue ALU tags 6,7; assert rob_cdb_rst_in -> cdb_b_out=0 next cycle, tags 6,7 never appear.
//  5 rdy_in low 3 cycles with queued tag 8 -> cdb_b_out held; tag 8 broadcast after rdy_in returns.
//  6 rst_n_in low mid-traffic, async -> outputs 0 before next edge, rdy_out=1, first grant ALU.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encodings and the queued result record for the CDB arbiter.
// Widths mirror the ROB tag and data widths used by the rest of the core.
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH = 5;
    localparam int ID_WIDTH  = 32;

    localparam int CDB_DEPTH = 2;
    localparam int CDB_PTR_W = 1;

    localparam logic CDB_SRC_ALU  = 1'b0;
    localparam logic CDB_SRC_LBUF = 1'b1;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] tag;
        logic [ID_WIDTH-1:0]  value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue: DEPTH-entry circular buffer with push, pop, flush and head peek.
// en_i low freezes all state; flush_i empties the queue and wins over push/pop.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH,
    parameter int PTR_W = CDB_PTR_W
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  cdb_entry_t push_data_i,
    input  logic       pop_i,
    output logic       empty_o,
    output logic       full_o,
    output cdb_entry_t head_o
);

    cdb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = en_i && !flush_i && push_i;
    assign do_pop  = en_i && !flush_i && pop_i;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign head_o  = mem_q[head_q];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i && flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
            else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= push_data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus scheduler: ALU and load-buffer results are queued and broadcast one per cycle, round-robin.
// Define CDB_ARB_BYPASS_EN to let a winning result that arrives at an empty queue skip it (1-cycle latency).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH,
    parameter int PTR_W = CDB_PTR_W
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 rob_cdb_rst_in,
    input  logic [ROB_WIDTH-1:0] alu_cdb_b_in,
    input  logic [ID_WIDTH-1:0]  alu_cdb_result_in,
    output logic                 cdb_alu_rdy_out,
    input  logic [ROB_WIDTH-1:0] lbuffer_cdb_b_in,
    input  logic [ID_WIDTH-1:0]  lbuffer_cdb_result_in,
    output logic                 cdb_lbuffer_rdy_out,
    output logic [ROB_WIDTH-1:0] cdb_b_out,
    output logic [ID_WIDTH-1:0]  cdb_result_out,
    output logic                 cdb_src_out
);

    cdb_entry_t alu_in, lb_in, alu_head, lb_head, win_entry;
    logic       alu_arrive, lb_arrive;
    logic       alu_empty, alu_full, lb_empty, lb_full;
    logic       alu_cand, lb_cand, alu_win, lb_win;
    logic       alu_bypass, lb_bypass;
    logic       alu_push, alu_pop, lb_push, lb_pop;
    logic       grant_src;

    logic [ROB_WIDTH-1:0] b_q, b_d;
    logic [ID_WIDTH-1:0]  result_q, result_d;
    logic                 src_q, src_d;
    logic                 last_grant_q, last_grant_d;

    assign alu_arrive = (alu_cdb_b_in != '0);
    assign lb_arrive  = (lbuffer_cdb_b_in != '0);
    assign alu_in     = {alu_cdb_b_in, alu_cdb_result_in};
    assign lb_in      = {lbuffer_cdb_b_in, lbuffer_cdb_result_in};

    // Readiness looks only at the registered count, so a full queue never admits a same-cycle push.
    assign cdb_alu_rdy_out     = !alu_full;
    assign cdb_lbuffer_rdy_out = !lb_full;

`ifdef CDB_ARB_BYPASS_EN
    assign alu_cand = !alu_empty || alu_arrive;
    assign lb_cand  = !lb_empty || lb_arrive;
`else
    assign alu_cand = !alu_empty;
    assign lb_cand  = !lb_empty;
`endif

    always_comb begin
        grant_src    = CDB_SRC_ALU;
        alu_bypass   = 1'b0;
        lb_bypass    = 1'b0;
        b_d          = b_q;
        result_d     = result_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;

        if (alu_cand && lb_cand) grant_src = ~last_grant_q;
        else if (lb_cand)        grant_src = CDB_SRC_LBUF;

        alu_win = alu_cand && (grant_src == CDB_SRC_ALU);
        lb_win  = lb_cand && (grant_src == CDB_SRC_LBUF);
`ifdef CDB_ARB_BYPASS_EN
        alu_bypass = alu_win && alu_empty;
        lb_bypass  = lb_win && lb_empty;
`endif
        if (lb_win) win_entry = lb_bypass ? lb_in : lb_head;
        else        win_entry = alu_bypass ? alu_in : alu_head;

        alu_pop  = alu_win && !alu_bypass;
        lb_pop   = lb_win && !lb_bypass;
        alu_push = alu_arrive && !alu_bypass;
        lb_push  = lb_arrive && !lb_bypass;

        if (rob_cdb_rst_in) begin
            b_d = '0;
        end else if (alu_win || lb_win) begin
            b_d          = win_entry.tag;
            result_d     = win_entry.value;
            src_d        = grant_src;
            last_grant_d = grant_src;
        end else begin
            b_d = '0;
        end
    end

    cdb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_alu_fifo (
        .clk_i       (clk_in),
        .rst_n_i     (rst_n_in),
        .en_i        (rdy_in),
        .flush_i     (rob_cdb_rst_in),
        .push_i      (alu_push),
        .push_data_i (alu_in),
        .pop_i       (alu_pop),
        .empty_o     (alu_empty),
        .full_o      (alu_full),
        .head_o      (alu_head)
    );

    cdb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lb_fifo (
        .clk_i       (clk_in),
        .rst_n_i     (rst_n_in),
        .en_i        (rdy_in),
        .flush_i     (rob_cdb_rst_in),
        .push_i      (lb_push),
        .push_data_i (lb_in),
        .pop_i       (lb_pop),
        .empty_o     (lb_empty),
        .full_o      (lb_full),
        .head_o      (lb_head)
    );

    // last_grant resets to the load buffer so the ALU wins the first contention.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            b_q          <= '0;
            result_q     <= '0;
            src_q        <= CDB_SRC_ALU;
            last_grant_q <= CDB_SRC_LBUF;
        end else if (rdy_in) begin
            b_q          <= b_d;
            result_q     <= result_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdb_b_out      = b_q;
    assign cdb_result_out = result_q;
    assign cdb_src_out    = src_q;

    alu_push_legal: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (rdy_in && !rob_cdb_rst_in && alu_arrive) |-> cdb_alu_rdy_out);

    lb_push_legal: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (rdy_in && !rob_cdb_rst_in && lb_arrive) |-> cdb_lbuffer_rdy_out);

endmodule
